// File: rtl/mips_fetch_pkg.sv
// Shared constants and the next-PC select encoding for the MIPS fetch stage.
package mips_fetch_pkg;

    // All-zero word decodes as sll $0,$0,0, so a bubble is a real NOP.
    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Source of the next PC, listed from lowest to highest priority.
    typedef enum logic [1:0] {
        SEL_SEQ = 2'd0,
        SEL_BR  = 2'd1,
        SEL_J   = 2'd2,
        SEL_JR  = 2'd3
    } npc_sel_e;

endpackage

// File: rtl/next_pc_sel.sv
// Picks the redirect source (jr > j > branch), forms the word-aligned
// target and flags a target whose low two bits were not zero.
module next_pc_sel
    import mips_fetch_pkg::*;
(
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [25:0] jump_index_i,
    input  logic        jump_reg_i,
    input  logic [31:0] jr_target_i,
    input  logic [3:0]  pc4_hi_i,      // ifid_pc4[31:28], the region of the jump
    output logic [1:0]  sel_o,
    output logic [31:0] target_o,
    output logic        misalign_o
);

    npc_sel_e    sel;
    logic [31:0] raw_target;

    // Priority select of the redirect target; SEQ means no redirect.
    always_comb begin
        sel        = SEL_SEQ;
        raw_target = branch_target_i;
        if (jump_reg_i) begin
            sel        = SEL_JR;
            raw_target = jr_target_i;
        end else if (jump_i) begin
            sel        = SEL_J;
            raw_target = {pc4_hi_i, jump_index_i, 2'b00};
        end else if (branch_taken_i) begin
            sel        = SEL_BR;
            raw_target = branch_target_i;
        end
    end

    assign sel_o      = sel;
    assign target_o   = {raw_target[31:2], 2'b00};
    assign misalign_o = (sel != SEL_SEQ) && (raw_target[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch_stage.sv
// IF stage: owns the PC, addresses the combinational instruction memory and
// loads the IF/ID register, honouring stall, flush and ID-stage redirects.
module instr_fetch_stage
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          IMEM_WORDS = 128
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jump_reg,
    input  logic [31:0] jr_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] ifid_inst,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        addr_fault
);

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);

    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;

    logic [1:0]  sel;
    logic [31:0] target;
    logic        misalign;
    logic        redirect;
    logic        out_of_range;
    logic [31:0] pc_plus4;

    next_pc_sel u_next_pc_sel (
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .jump_i          (jump),
        .jump_index_i    (jump_index),
        .jump_reg_i      (jump_reg),
        .jr_target_i     (jr_target),
        .pc4_hi_i        (pc4_q[31:28]),
        .sel_o           (sel),
        .target_o        (target),
        .misalign_o      (misalign)
    );

    assign redirect     = (sel != SEL_SEQ);
    assign pc_plus4     = pc_q + 32'd4;
    assign out_of_range = ({2'b00, pc_q[31:2]} >= IMEM_LIMIT);

    // Next-state for PC, IF/ID and the fault pulse; redirect beats stall.
    always_comb begin
        pc_d    = pc_plus4;
        inst_d  = inst_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        fault_d = misalign;

        if (redirect)   pc_d = target;
        else if (stall) pc_d = pc_q;

        if (flush || redirect) begin
            inst_d  = NOP_INST;
            pc4_d   = 32'd0;
            valid_d = 1'b0;
        end else if (!stall) begin
            if (out_of_range) begin
                inst_d  = NOP_INST;
                pc4_d   = 32'd0;
                valid_d = 1'b0;
                fault_d = 1'b1;
            end else begin
                inst_d  = imem_data;
                pc4_d   = pc_plus4;
                valid_d = 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    assign imem_addr  = pc_q;
    assign ifid_inst  = inst_q;
    assign ifid_pc4   = pc4_q;
    assign ifid_valid = valid_q;
    assign addr_fault = fault_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed plus randomized bench for instr_fetch_stage against a
// behavioural fetch model kept here.
module tb_instr_fetch_stage;

    logic        CLK = 1'b0;
    logic        RESET, stall, flush, branch_taken, jump, jump_reg;
    logic [31:0] branch_target, jr_target;
    logic [25:0] jump_index;
    logic [31:0] imem_addr, imem_data, ifid_inst, ifid_pc4;
    logic        ifid_valid, addr_fault;

    logic [31:0] mem [0:127];

    int n_total = 0;
    int n_pass  = 0;

    // Behavioural view of the stage state.
    logic [31:0] m_pc, m_inst, m_pc4;
    logic        m_valid, m_fault;

    instr_fetch_stage #(.RESET_PC(32'h0), .IMEM_WORDS(128)) dut (
        .CLK(CLK), .RESET(RESET), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_index(jump_index),
        .jump_reg(jump_reg), .jr_target(jr_target),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .ifid_inst(ifid_inst), .ifid_pc4(ifid_pc4),
        .ifid_valid(ifid_valid), .addr_fault(addr_fault)
    );

    always #5 CLK = ~CLK;

    assign imem_data = (imem_addr[31:2] < 30'd128) ? mem[imem_addr[8:2]] : 32'hDEAD_BEEF;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr / 4 < 128) return mem[addr / 4];
        return 32'hDEAD_BEEF;
    endfunction

    // Advance the model by one clock edge using the inputs now applied.
    function automatic void model_edge();
        logic [31:0] tgt;
        logic        redir, in_range;
        if (!RESET) begin
            m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_fault = 1'b0;
            return;
        end
        redir = jump_reg | jump | branch_taken;
        if (jump_reg)  tgt = jr_target;
        else if (jump) tgt = {m_pc4[31:28], jump_index, 2'b00};
        else           tgt = branch_target;
        in_range = (m_pc / 4) < 128;
        m_fault = (redir && (tgt % 4 != 0)) || (!redir && !stall && !flush && !in_range);
        if (flush || redir) begin
            m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (!stall) begin
            if (in_range) begin
                m_inst = mem_word(m_pc); m_pc4 = m_pc + 4; m_valid = 1'b1;
            end else begin
                m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            end
        end
        if (redir)      m_pc = tgt - (tgt % 4);
        else if (!stall) m_pc = m_pc + 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One clock: predict, clock, sample 1 time unit after the edge, compare.
    task automatic step(input string tag);
        model_edge();
        @(posedge CLK);
        #1;
        chk({tag, ".addr"},  imem_addr, m_pc);
        chk({tag, ".inst"},  ifid_inst, m_inst);
        chk({tag, ".pc4"},   ifid_pc4,  m_pc4);
        chk({tag, ".valid"}, 32'(ifid_valid), 32'(m_valid));
        chk({tag, ".fault"}, 32'(addr_fault), 32'(m_fault));
    endtask

    task automatic idle();
        stall = 0; flush = 0; branch_taken = 0; jump = 0; jump_reg = 0;
        branch_target = 0; jr_target = 0; jump_index = 0;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h2008_0001 + i;
        m_pc = 0; m_inst = 0; m_pc4 = 0; m_valid = 0; m_fault = 0;
        idle();
        RESET = 0;
        step("reset0");
        step("reset1");
        chk("reset.addr_const", imem_addr, 32'h0);
        RESET = 1;

        // free run from address 0
        step("run0");
        chk("run0.inst_const", ifid_inst, 32'h2008_0001);
        chk("run0.pc4_const",  ifid_pc4,  32'h4);
        step("run1");
        // stall at PC=8 for two cycles
        chk("pre_stall.addr_const", imem_addr, 32'h8);
        stall = 1;
        step("stall0");
        step("stall1");
        stall = 0;
        step("resume");
        chk("resume.addr_const", imem_addr, 32'hC);

        // taken branch to 0x40
        branch_taken = 1; branch_target = 32'h40;
        step("branch");
        idle();
        step("br_fetch");
        chk("br_fetch.pc4_const", ifid_pc4, 32'h44);

        // jump wins over branch, then jr wins over both with a misaligned target
        jump = 1; jump_index = 26'h20; branch_taken = 1; branch_target = 32'h40;
        step("jump");
        chk("jump.addr_const", imem_addr, 32'h80);
        jump_reg = 1; jr_target = 32'h62;
        step("jr_mis");
        chk("jr_mis.fault_const", 32'(addr_fault), 32'h1);
        idle();
        step("jr_after");

        // run past the end of instruction memory
        branch_taken = 1; branch_target = 32'h1F8;
        step("to_end");
        idle();
        step("end0");
        step("end1");
        step("oor0");
        chk("oor0.addr_const", imem_addr, 32'h204);
        step("oor1");
        flush = 1;
        step("oor_flush");
        flush = 0;

        // 32-bit PC wraparound
        branch_taken = 1; branch_target = 32'hFFFF_FFFC;
        step("to_wrap");
        idle();
        step("wrap");
        chk("wrap.addr_const", imem_addr, 32'h0);

        // reset asserted while stalled at 0x24
        branch_taken = 1; branch_target = 32'h24;
        step("to_24");
        idle();
        stall = 1;
        step("stall24");
        RESET = 0;
        step("rst_in_stall");
        RESET = 1; stall = 0;
        step("post_rst");

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            RESET         = ($urandom_range(0, 49) != 0);
            stall         = ($urandom_range(0, 5) == 0);
            flush         = ($urandom_range(0, 7) == 0);
            branch_taken  = ($urandom_range(0, 9) == 0);
            jump          = ($urandom_range(0, 14) == 0);
            jump_reg      = ($urandom_range(0, 19) == 0);
            branch_target = $urandom_range(0, 32'h220);
            jr_target     = $urandom_range(0, 32'h220);
            jump_index    = 26'($urandom_range(0, 32'h90));
            if ($urandom_range(0, 30) == 0) branch_target = 32'hFFFF_FFF4;
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
- IF stage of the multi-cycle pipelined MIPS core.
- Owns the program counter and drives the word address into the combinational-read instruction memory.
- Captures the returned instruction into the IF/ID pipeline register.
- Handles stall, flush, and branch/jump/jr redirects from the ID stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_WORDS, 128, instruction memory depth in 32-bit words; word index >= IMEM_WORDS is out of range.

Ports:
- CLK  input  1  rising-edge clock
- RESET  input  1  synchronous, active-low reset (0 = reset, sampled on CLK rising edge)
- stall  input  1  hazard unit: hold PC and IF/ID
- flush  input  1  squash IF/ID contents (insert bubble)
- branch_taken  input  1  ID resolved a taken branch
- branch_target  input  32  byte address of branch target
- jump  input  1  ID decoded j/jal
- jump_index  input  26  instr[25:0] of the jump in ID
- jump_reg  input  1  ID decoded jr/jalr
- jr_target  input  32  register value for jr/jalr
- imem_addr  output  32  byte address to instruction memory, equals PC (combinational)
- imem_data  input  32  instruction word from memory, valid same cycle as imem_addr
- ifid_inst  output  32  registered instruction
- ifid_pc4  output  32  registered PC+4 of that instruction
- ifid_valid  output  1  registered: IF/ID holds a real instruction
- addr_fault  output  1  registered one-cycle pulse: misaligned redirect or out-of-range fetch

Behaviour:
- Reset (RESET==0 at edge):
  - PC=RESET_PC, ifid_inst=0, ifid_pc4=0, ifid_valid=0, addr_fault=0.
  - Reset overrides every other input.
- imem_addr = PC at all times; no extra latency. Instruction fetched in cycle N appears on ifid_* after edge N+1.
- Redirect priority: jump_reg > jump > branch_taken.
  - Jump target = {ifid_pc4[31:28], jump_index, 2'b00}.
  - Redirect = any of the three asserted.
- Next PC per edge, first match wins:
  1. reset
  2. redirect: PC=target with bits[1:0] forced to 00
  3. stall: PC held
  4. otherwise PC=PC+4, 32-bit wraparound (32'hFFFF_FFFC -> 0)
- Redirect is honoured even when stall=1. The hazard unit guarantees stall and redirect do not both originate from the same ID instruction.
- IF/ID register per edge, first match wins:
  1. reset
  2. flush or redirect: bubble (ifid_inst=0 i.e. NOP sll $0,$0,0, ifid_pc4=0, ifid_valid=0)
  3. stall: hold all three
  4. out-of-range fetch (PC[31:2] >= IMEM_WORDS): bubble
  5. otherwise ifid_inst=imem_data, ifid_pc4=PC+4, ifid_valid=1
- addr_fault:
  - Set for exactly one cycle after an edge where the selected redirect target has bits[1:0]!=0, or condition 4 held while not stalled/flushed/redirected.
  - Cleared otherwise.
  - Not sticky.
- Continuous stall: PC and IF/ID frozen indefinitely, no faults re-raised.
- Reset asserted mid-stall or mid-redirect: reset values next cycle. First fetch after release is at RESET_PC.

Decomposition:
- Package mips_fetch_pkg holds:
  - NOP_INST=32'h0000_0000
  - default RESET_PC
  - 2-bit next-PC select encoding (SEQ, BR, J, JR)
- One combinational sub-module next_pc_sel computes the select code, the aligned target and the misalign flag.
- PC and IF/ID registers stay in instr_fetch_stage.

Test Plan:
- Reset then free-run 4 cycles, memory words 0..3 = 32'h20080001..04 -> imem_addr 0,4,8,C; ifid_inst 20080001 with ifid_pc4=4 one cycle after addr 0; ifid_valid=1.
- stall=1 for 2 cycles at PC=8 -> imem_addr stays 8, ifid_* unchanged both cycles; resumes at C.
- branch_taken with branch_target=32'h40 at PC=C -> next imem_addr=40, IF/ID bubble (inst 0, valid 0), then word 16 captured with pc4=44.
- jump and branch_taken both set, ifid_pc4=32'h0000_0010, jump_index=26'h20 -> PC=32'h80, branch ignored. jump_reg with jr_target=32'h62 in the same cycle -> PC=32'h60 and addr_fault=1 for one cycle.
- PC reaches 32'h200 (word 128, IMEM_WORDS=128) -> IF/ID bubble, addr_fault pulses while PC advances to 204.
- RESET low during stall=1 at PC=24 -> PC=0, ifid_valid=0, addr_fault=0 the next cycle.
